// File: rtl/branch_predict_resolve.sv
// Branch/jump resolver with a direct-mapped BTB. Fetch lookup is combinational; resolution is registered (1 cycle).
// stall freezes every register and the BTB; there is no other backpressure.
module branch_predict_resolve #(
  parameter int         XLEN        = 32,
  parameter int         BTB_ENTRIES = 8,
  parameter logic [4:0] LINK_REG    = 5'd31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            in_valid,
  input  logic            stall,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus_four,
  input  logic [XLEN-1:0] rs1,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            out_valid,
  output logic            take_branch,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            link_we,
  output logic [4:0]      link_sel,
  output logic [XLEN-1:0] link_data,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispred
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_JR   = 6'h12;
  localparam logic [5:0] OP_JALR = 6'h13;

  // BTB storage
  logic            valid_q [BTB_ENTRIES];
  logic [1:0]      ctr_q   [BTB_ENTRIES];
  logic [TAGW-1:0] tag_q   [BTB_ENTRIES];
  logic [XLEN-1:0] tgt_q   [BTB_ENTRIES];

  // Fetch-side lookup sees only pre-edge contents, so no bypass from the decode update.
  logic [IDX-1:0]  f_idx;
  logic [TAGW-1:0] f_tag;

  assign f_idx       = fetch_pc[IDX+1:2];
  assign f_tag       = fetch_pc[XLEN-1:IDX+2];
  assign pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = pred_hit && ctr_q[f_idx][1];
  assign pred_target = pred_hit ? tgt_q[f_idx] : '0;

  logic [IDX-1:0]  d_idx;
  logic [TAGW-1:0] d_tag;
  logic            d_hit;

  assign d_idx = pc[IDX+1:2];
  assign d_tag = pc[XLEN-1:IDX+2];
  assign d_hit = valid_q[d_idx] && (tag_q[d_idx] == d_tag);

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pc[1:0], fetch_pc[1:0]};

  logic [5:0]      opcode;
  logic [XLEN-1:0] imm26_sext;
  logic [XLEN-1:0] imm16_sext;
  logic            is_ctl;
  logic            is_uncond;
  logic            is_link;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            mispred;
  logic            sample;

  assign opcode     = instruction[31:26];
  assign imm26_sext = {{(XLEN-26){instruction[25]}}, instruction[25:0]};
  assign imm16_sext = {{(XLEN-16){instruction[15]}}, instruction[15:0]};

  always_comb begin
    is_ctl    = 1'b0;
    is_uncond = 1'b0;
    is_link   = 1'b0;
    taken     = 1'b0;
    target    = '0;
    case (opcode)
      OP_J, OP_JAL: begin
        is_ctl    = 1'b1;
        is_uncond = 1'b1;
        is_link   = (opcode == OP_JAL);
        taken     = 1'b1;
        target    = pc_plus_four + imm26_sext;
      end
      OP_JR, OP_JALR: begin
        is_ctl    = 1'b1;
        is_uncond = 1'b1;
        is_link   = (opcode == OP_JALR);
        taken     = 1'b1;
        target    = rs1;
      end
      OP_BEQZ, OP_BNEZ: begin
        is_ctl = 1'b1;
        taken  = (opcode == OP_BEQZ) ? (rs1 == '0) : (rs1 != '0);
        target = pc_plus_four + imm16_sext;
      end
      default: ;
    endcase
  end

  // A predicted-taken non-control instruction is a stale BTB alias and must also redirect.
  assign next_pc = taken ? target : pc_plus_four;
  assign mispred = taken ? (!in_pred_taken || (in_pred_target != target)) : in_pred_taken;
  assign sample  = in_valid && !stall;

  logic            btb_we;
  logic            ent_valid_d;
  logic [1:0]      ent_ctr_d;
  logic [TAGW-1:0] ent_tag_d;
  logic [XLEN-1:0] ent_tgt_d;

  always_comb begin
    btb_we      = 1'b0;
    ent_valid_d = valid_q[d_idx];
    ent_ctr_d   = ctr_q[d_idx];
    ent_tag_d   = tag_q[d_idx];
    ent_tgt_d   = tgt_q[d_idx];
    if (sample) begin
      if (is_ctl && d_hit) begin
        btb_we = 1'b1;
        if (taken) ent_tgt_d = target;
        if (is_uncond)             ent_ctr_d = 2'b11;
        else if (taken)            ent_ctr_d = (ctr_q[d_idx] == 2'b11) ? 2'b11 : ctr_q[d_idx] + 2'd1;
        else                       ent_ctr_d = (ctr_q[d_idx] == 2'b00) ? 2'b00 : ctr_q[d_idx] - 2'd1;
      end else if (is_ctl && taken) begin
        btb_we      = 1'b1;
        ent_valid_d = 1'b1;
        ent_tag_d   = d_tag;
        ent_tgt_d   = target;
        ent_ctr_d   = is_uncond ? 2'b11 : 2'b10;
      end else if (!is_ctl && d_hit) begin
        btb_we      = 1'b1;
        ent_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (btb_we) begin
      valid_q[d_idx] <= ent_valid_d;
      ctr_q[d_idx]   <= ent_ctr_d;
      tag_q[d_idx]   <= ent_tag_d;
      tgt_q[d_idx]   <= ent_tgt_d;
    end
  end

  logic            out_valid_q,   out_valid_d;
  logic            take_q,        take_d;
  logic            redirect_q,    redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            link_we_q,     link_we_d;
  logic [4:0]      link_sel_q,    link_sel_d;
  logic [XLEN-1:0] link_data_q,   link_data_d;
  logic [31:0]     perf_br_q,     perf_br_d;
  logic [31:0]     perf_mp_q,     perf_mp_d;

  always_comb begin
    out_valid_d   = out_valid_q;
    take_d        = take_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    link_we_d     = link_we_q;
    link_sel_d    = link_sel_q;
    link_data_d   = link_data_q;
    perf_br_d     = perf_br_q;
    perf_mp_d     = perf_mp_q;
    if (sample) begin
      out_valid_d   = 1'b1;
      take_d        = taken;
      redirect_d    = mispred;
      redirect_pc_d = next_pc;
      link_we_d     = is_link;
      link_sel_d    = LINK_REG;
      link_data_d   = pc_plus_four;
      if (is_ctl && (perf_br_q != 32'hFFFF_FFFF)) perf_br_d = perf_br_q + 32'd1;
      if (mispred && (perf_mp_q != 32'hFFFF_FFFF)) perf_mp_d = perf_mp_q + 32'd1;
    end else if (!stall) begin
      out_valid_d = 1'b0;
      take_d      = 1'b0;
      redirect_d  = 1'b0;
      link_we_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      take_q        <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      link_we_q     <= 1'b0;
      link_sel_q    <= 5'd0;
      link_data_q   <= '0;
      perf_br_q     <= 32'd0;
      perf_mp_q     <= 32'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      take_q        <= take_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      link_we_q     <= link_we_d;
      link_sel_q    <= link_sel_d;
      link_data_q   <= link_data_d;
      perf_br_q     <= perf_br_d;
      perf_mp_q     <= perf_mp_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign take_branch   = take_q;
  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;
  assign link_we       = link_we_q;
  assign link_sel      = link_sel_q;
  assign link_data     = link_data_q;
  assign perf_branches = perf_br_q;
  assign perf_mispred  = perf_mp_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: spec-level model compared every cycle, plus literal spot checks.
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] pc = '0;
  logic [31:0] pc_plus_four = '0;
  logic [31:0] rs1 = '0;
  logic        in_pred_taken = 1'b0;
  logic [31:0] in_pred_target = '0;
  logic        out_valid, take_branch, redirect, link_we;
  logic [31:0] redirect_pc, link_data, perf_branches, perf_mispred;
  logic [4:0]  link_sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_predict_resolve #(.XLEN(32), .BTB_ENTRIES(8), .LINK_REG(5'd31)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .in_valid(in_valid), .stall(stall), .instruction(instruction), .pc(pc),
    .pc_plus_four(pc_plus_four), .rs1(rs1), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .out_valid(out_valid), .take_branch(take_branch),
    .redirect(redirect), .redirect_pc(redirect_pc), .link_we(link_we), .link_sel(link_sel),
    .link_data(link_data), .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // Reference model: BTB as plain arrays, counters as integers 0..3.
  logic        m_valid [8];
  int          m_ctr   [8];
  logic [31:0] m_tag   [8];
  logic [31:0] m_tgt   [8];
  logic        m_ov, m_tb, m_rd, m_lwe;
  logic [31:0] m_rpc, m_ld, m_pb, m_pm;
  logic [4:0]  m_ls;

  logic        mo_ctl, mo_unc, mo_taken, mo_hit;
  logic [31:0] mo_tgt;
  int          mo_i;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_valid[i] = 1'b0; m_ctr[i] = 1; m_tag[i] = '0; m_tgt[i] = '0;
      end
      m_ov = 0; m_tb = 0; m_rd = 0; m_lwe = 0; m_rpc = 0; m_ld = 0; m_ls = 0; m_pb = 0; m_pm = 0;
    end else if (!stall) begin
      if (!in_valid) begin
        m_ov = 0; m_tb = 0; m_rd = 0; m_lwe = 0;
      end else begin
        mo_ctl = 1; mo_unc = 0; mo_taken = 0; mo_tgt = 0;
        case (instruction[31:26])
          6'h02, 6'h03: begin
            mo_unc = 1; mo_taken = 1;
            mo_tgt = pc_plus_four + 32'(int'($signed(instruction[25:0])));
          end
          6'h12, 6'h13: begin mo_unc = 1; mo_taken = 1; mo_tgt = rs1; end
          6'h04: begin mo_taken = (rs1 == 0); mo_tgt = pc_plus_four + 32'(int'($signed(instruction[15:0]))); end
          6'h05: begin mo_taken = (rs1 != 0); mo_tgt = pc_plus_four + 32'(int'($signed(instruction[15:0]))); end
          default: mo_ctl = 0;
        endcase
        m_ov  = 1;
        m_tb  = mo_taken;
        m_rd  = (mo_taken && (!in_pred_taken || in_pred_target != mo_tgt)) || (!mo_taken && in_pred_taken);
        m_rpc = mo_taken ? mo_tgt : pc_plus_four;
        m_lwe = (instruction[31:26] == 6'h03) || (instruction[31:26] == 6'h13);
        m_ls  = 5'd31;
        m_ld  = pc_plus_four;
        if (mo_ctl && m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
        if (m_rd && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 1;
        mo_i   = int'((pc / 4) % 8);
        mo_hit = m_valid[mo_i] && (m_tag[mo_i] == pc / 32);
        if (mo_ctl && mo_hit) begin
          if (mo_taken) m_tgt[mo_i] = mo_tgt;
          if (mo_unc) m_ctr[mo_i] = 3;
          else if (mo_taken) m_ctr[mo_i] = (m_ctr[mo_i] < 3) ? m_ctr[mo_i] + 1 : 3;
          else m_ctr[mo_i] = (m_ctr[mo_i] > 0) ? m_ctr[mo_i] - 1 : 0;
        end else if (mo_ctl && mo_taken) begin
          m_valid[mo_i] = 1; m_tag[mo_i] = pc / 32; m_tgt[mo_i] = mo_tgt; m_ctr[mo_i] = mo_unc ? 3 : 2;
        end else if (!mo_ctl && mo_hit) begin
          m_valid[mo_i] = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  int  cp_i;
  logic cp_hit;
  always @(negedge clk) begin
    if (!reset) begin
      cp_i   = int'((fetch_pc / 4) % 8);
      cp_hit = m_valid[cp_i] && (m_tag[cp_i] == fetch_pc / 32);
      check1("pred_hit", pred_hit, cp_hit);
      check1("pred_taken", pred_taken, cp_hit && (m_ctr[cp_i] >= 2));
      check("pred_target", pred_target, cp_hit ? m_tgt[cp_i] : 32'h0);
      check1("out_valid", out_valid, m_ov);
      check1("take_branch", take_branch, m_tb);
      check1("redirect", redirect, m_rd);
      check("redirect_pc", redirect_pc, m_rpc);
      check1("link_we", link_we, m_lwe);
      check("link_sel", {27'b0, link_sel}, {27'b0, m_ls});
      check("link_data", link_data, m_ld);
      check("perf_branches", perf_branches, m_pb);
      check("perf_mispred", perf_mispred, m_pm);
    end
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [25:0] imm);
    return {op, imm};
  endfunction

  task automatic issue(input logic v, input logic [31:0] ins, input logic [31:0] p, input logic [31:0] r1,
                       input logic pt, input logic [31:0] ptg, input logic st);
    in_valid = v; instruction = ins; pc = p; pc_plus_four = p + 32'd4; rs1 = r1;
    in_pred_taken = pt; in_pred_target = ptg; stall = st;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    issue(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 0; stall = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic look(input string nm, input logic [31:0] fpc, input logic eh, input logic et);
    fetch_pc = fpc; #1;
    check1({nm, "_hit"}, pred_hit, eh);
    check1({nm, "_taken"}, pred_taken, et);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_link_sel", {27'b0, link_sel}, 32'h0);
    check("rst_perf_br", perf_branches, 32'h0);
    fetch_pc = 32'h100; #1;
    check1("rst_pred_hit", pred_hit, 1'b0);
    check("rst_pred_target", pred_target, 32'h0);
    #1 reset = 1'b0;

    // jal at 0x100, imm 0x10, not predicted
    issue(1, enc(6'h03, 26'h10), 32'h100, 0, 0, 0, 0);
    check1("jal_redirect", redirect, 1'b1);
    check("jal_redirect_pc", redirect_pc, 32'h114);
    check1("jal_link_we", link_we, 1'b1);
    check("jal_link_sel", {27'b0, link_sel}, 32'd31);
    check("jal_link_data", link_data, 32'h104);
    look("jal_lookup", 32'h100, 1'b1, 1'b1);
    check("jal_pred_target", pred_target, 32'h114);

    // beqz at 0x200, offset -16: taken x3 then not taken
    issue(1, enc(6'h04, 26'hFFF0), 32'h200, 0, 0, 0, 0);
    check1("bq1_redirect", redirect, 1'b1);
    check("bq1_redirect_pc", redirect_pc, 32'h1F4);
    issue(1, enc(6'h04, 26'hFFF0), 32'h200, 0, 1, 32'h1F4, 0);
    check1("bq2_redirect", redirect, 1'b0);
    issue(1, enc(6'h04, 26'hFFF0), 32'h200, 0, 1, 32'h1F4, 0);
    check1("bq3_redirect", redirect, 1'b0);
    issue(1, enc(6'h04, 26'hFFF0), 32'h200, 5, 1, 32'h1F4, 0);
    check1("bq4_redirect", redirect, 1'b1);
    check("bq4_redirect_pc", redirect_pc, 32'h204);
    check1("bq4_take", take_branch, 1'b0);
    look("bq4_lookup", 32'h200, 1'b1, 1'b1);
    issue(1, enc(6'h04, 26'hFFF0), 32'h200, 5, 0, 0, 0);
    look("bq5_lookup", 32'h200, 1'b1, 1'b0);

    // bnez not taken, fresh counters
    do_reset();
    issue(1, enc(6'h05, 26'h40), 32'h300, 0, 0, 0, 0);
    check1("bnz_take", take_branch, 1'b0);
    check1("bnz_redirect", redirect, 1'b0);
    check("bnz_perf_br", perf_branches, 32'd1);
    check("bnz_perf_mp", perf_mispred, 32'd0);
    look("bnz_lookup", 32'h300, 1'b0, 1'b0);

    // stall holds outputs and BTB
    issue(1, enc(6'h03, 26'h10), 32'h400, 0, 0, 0, 0);
    issue(1, enc(6'h02, 26'h20), 32'h500, 0, 0, 0, 1);
    issue(1, enc(6'h04, 26'h8), 32'h600, 0, 0, 0, 1);
    check("stall_redirect_pc", redirect_pc, 32'h414);
    check1("stall_link_we", link_we, 1'b1);
    look("stall_lookup", 32'h500, 1'b0, 1'b0);
    issue(1, enc(6'h02, 26'h20), 32'h500, 0, 0, 0, 0);
    check("rel_redirect_pc", redirect_pc, 32'h524);
    check1("rel_link_we", link_we, 1'b0);
    look("rel_lookup", 32'h500, 1'b1, 1'b1);

    // jr to top of memory, then wrapping beqz target
    issue(1, enc(6'h12, 26'h0), 32'h600, 32'hFFFF_FFFC, 1, 32'h0, 0);
    check1("jr_redirect", redirect, 1'b1);
    check("jr_redirect_pc", redirect_pc, 32'hFFFF_FFFC);
    issue(1, enc(6'h04, 26'h0008), 32'hFFFF_FFF8, 0, 0, 0, 0);
    check("wrap_redirect_pc", redirect_pc, 32'h4);
    look("wrap_lookup", 32'hFFFF_FFF8, 1'b1, 1'b1);

    // asynchronous reset mid-burst
    in_valid = 1; instruction = enc(6'h03, 26'h4); pc = 32'h700; pc_plus_four = 32'h704;
    in_pred_taken = 0; stall = 0;
    @(posedge clk); #3;
    reset = 1'b1; in_valid = 0; #1;
    check1("arst_out_valid", out_valid, 1'b0);
    check1("arst_redirect", redirect, 1'b0);
    check("arst_redirect_pc", redirect_pc, 32'h0);
    check("arst_link_data", link_data, 32'h0);
    check("arst_perf_br", perf_branches, 32'h0);
    check("arst_perf_mp", perf_mispred, 32'h0);
    check1("arst_pred_hit", pred_hit, 1'b0);
    @(negedge clk); #1 reset = 1'b0;

    // non-control instruction aliasing a BTB entry
    issue(1, enc(6'h03, 26'h10), 32'h100, 0, 0, 0, 0);
    issue(1, enc(6'h00, 26'h0), 32'h100, 0, 1, 32'h114, 0);
    check1("alias_redirect", redirect, 1'b1);
    check("alias_redirect_pc", redirect_pc, 32'h104);
    check1("alias_take", take_branch, 1'b0);
    check("alias_perf_br", perf_branches, 32'd1);
    check("alias_perf_mp", perf_mispred, 32'd2);
    look("alias_lookup", 32'h100, 1'b0, 1'b0);

    idle();
    check1("idle_out_valid", out_valid, 1'b0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
